// File: rtl/round_sequencer.sv
// round_sequencer: round flow controller for the four-column falling-light game.
// Walks a round through IDLE -> ARM -> PLAY -> WIN/LOSE, generates the bank step
// strobe, arbitrates new-note spawns round-robin, and tracks lives and level.
// Every output comes straight from a register.
module round_sequencer #(
  parameter int TICK_BASE = 16,  // cycles per step at level 0 (power of 2, >= 8)
  parameter int ARM_STEPS = 3,   // countdown steps spent in ARM
  parameter int LIVES     = 3,   // misses allowed per round (1..7)
  parameter int WIN_SCORE = 24,  // score that ends the round as a win (<= 31)
  parameter int LEVEL_PTS = 6    // score points per level increase
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [4:0] i_score,
  input  logic [3:0] i_miss,
  input  logic [3:0] i_busy,
  input  logic [3:0] i_rnd,
  output logic       o_step,
  output logic [3:0] o_spawn,
  output logic       o_stop,
  output logic       o_clear,
  output logic [1:0] o_level,
  output logic [2:0] o_lives,
  output logic [2:0] o_state
);

  localparam int DIV_W = (TICK_BASE > 1) ? $clog2(TICK_BASE) : 1;
  localparam int ARM_W = (ARM_STEPS > 1) ? $clog2(ARM_STEPS) : 1;

  // Terminal counts for each level: the step period halves per level.
  localparam logic [DIV_W-1:0] TC_L0 = DIV_W'(TICK_BASE - 1);
  localparam logic [DIV_W-1:0] TC_L1 = DIV_W'((TICK_BASE >> 1) - 1);
  localparam logic [DIV_W-1:0] TC_L2 = DIV_W'((TICK_BASE >> 2) - 1);
  localparam logic [DIV_W-1:0] TC_L3 = DIV_W'((TICK_BASE >> 3) - 1);
  localparam logic [ARM_W-1:0] ARM_LAST   = ARM_W'(ARM_STEPS - 1);
  localparam logic [2:0]       LIVES_INIT = 3'(LIVES);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_PLAY = 3'd2,
    S_WIN  = 3'd3,
    S_LOSE = 3'd4
  } state_t;

  // Registered state and outputs
  state_t           r_state;
  logic [DIV_W-1:0] r_div;      // cycles elapsed in the current step period
  logic [DIV_W-1:0] r_tc;       // terminal count latched at the last reload
  logic [ARM_W-1:0] r_arm_cnt;  // ARM countdown steps already taken
  logic [1:0]       r_rr;       // round-robin search start column
  logic             r_step;
  logic [3:0]       r_spawn;
  logic             r_stop;
  logic             r_clear;
  logic [1:0]       r_level;
  logic [2:0]       r_lives;

  // Next-state values
  state_t           w_state_next;
  logic [DIV_W-1:0] w_div_next;
  logic [DIV_W-1:0] w_tc_next;
  logic [ARM_W-1:0] w_arm_next;
  logic [1:0]       w_rr_next;
  logic             w_step_next;
  logic [3:0]       w_spawn_next;
  logic             w_clear_next;
  logic [1:0]       w_level_next;
  logic [2:0]       w_lives_next;

  // Helpers
  logic             w_tick;
  logic [DIV_W-1:0] w_tc_reload;
  logic [2:0]       w_miss_cnt;
  logic [2:0]       w_lives_dec;
  logic [1:0]       w_level_calc;
  logic             w_win;
  logic [3:0]       w_cand;
  logic [3:0]       w_rot;
  logic [1:0]       w_off;
  logic [1:0]       w_grant;
  logic [3:0]       w_grant_oh;

  assign w_tick = (r_div == r_tc);

  // Period for the next step interval comes from the level held right now,
  // so a level change only alters timing at a reload.
  always_comb begin
    case (r_level)
      2'd0:    w_tc_reload = TC_L0;
      2'd1:    w_tc_reload = TC_L1;
      2'd2:    w_tc_reload = TC_L2;
      default: w_tc_reload = TC_L3;
    endcase
  end

  // Several columns can miss in one cycle; each costs a life.
  assign w_miss_cnt  = 3'(i_miss[0]) + 3'(i_miss[1]) + 3'(i_miss[2]) + 3'(i_miss[3]);
  assign w_lives_dec = (r_lives > w_miss_cnt) ? (r_lives - w_miss_cnt) : 3'd0;

  // Level from score with a compare chain instead of a divider.
  always_comb begin
    if (int'(i_score) >= 3 * LEVEL_PTS)      w_level_calc = 2'd3;
    else if (int'(i_score) >= 2 * LEVEL_PTS) w_level_calc = 2'd2;
    else if (int'(i_score) >= LEVEL_PTS)     w_level_calc = 2'd1;
    else                                     w_level_calc = 2'd0;
  end

  assign w_win = (int'(i_score) >= WIN_SCORE);

  // Spawn candidates: random request on a column that is currently empty.
  assign w_cand = i_rnd & ~i_busy;

  // Rotate candidates so bit 0 is the column the round-robin search starts at.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      assign w_rot[gi] = w_cand[r_rr + 2'(gi)];
    end
  endgenerate

  // First candidate found walking upward from the round-robin pointer.
  always_comb begin
    if (w_rot[0])      w_off = 2'd0;
    else if (w_rot[1]) w_off = 2'd1;
    else if (w_rot[2]) w_off = 2'd2;
    else               w_off = 2'd3;
  end

  assign w_grant    = r_rr + w_off;
  assign w_grant_oh = 4'b0001 << w_grant;

  // Next-state and output decode for the round flow.
  always_comb begin
    w_state_next = r_state;
    w_div_next   = r_div;
    w_tc_next    = r_tc;
    w_arm_next   = r_arm_cnt;
    w_rr_next    = r_rr;
    w_step_next  = 1'b0;
    w_spawn_next = 4'd0;
    w_clear_next = 1'b0;
    w_level_next = r_level;
    w_lives_next = r_lives;

    case (r_state)
      S_IDLE, S_WIN, S_LOSE: begin
        w_div_next = '0;
        if (i_start) begin
          w_state_next = S_ARM;
          w_clear_next = 1'b1;
          w_lives_next = LIVES_INIT;
          w_level_next = 2'd0;
          w_tc_next    = TC_L0;
          w_arm_next   = '0;
        end
      end

      S_ARM: begin
        if (w_tick) begin
          w_div_next  = '0;
          w_tc_next   = w_tc_reload;
          w_step_next = 1'b1;
          if (r_arm_cnt == ARM_LAST) begin
            w_arm_next   = '0;
            w_state_next = S_PLAY;
          end else begin
            w_arm_next = r_arm_cnt + ARM_W'(1);
          end
        end else begin
          w_div_next = r_div + DIV_W'(1);
        end
      end

      S_PLAY: begin
        w_lives_next = w_lives_dec;
        w_level_next = w_level_calc;
        // Losing outranks winning; the round ends without a final step.
        if (w_lives_dec == 3'd0) begin
          w_state_next = S_LOSE;
          w_div_next   = '0;
        end else if (w_win) begin
          w_state_next = S_WIN;
          w_div_next   = '0;
        end else if (w_tick) begin
          w_div_next  = '0;
          w_tc_next   = w_tc_reload;
          w_step_next = 1'b1;
          if (w_cand != 4'd0) begin
            w_spawn_next = w_grant_oh;
            w_rr_next    = w_grant + 2'd1;
          end
        end else begin
          w_div_next = r_div + DIV_W'(1);
        end
      end

      default: begin
        w_state_next = S_IDLE;
        w_div_next   = '0;
      end
    endcase
  end

  // State and output registers; reset forces the idle, frozen condition.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_tc      <= TC_L0;
      r_arm_cnt <= '0;
      r_rr      <= 2'd0;
      r_step    <= 1'b0;
      r_spawn   <= 4'd0;
      r_stop    <= 1'b1;
      r_clear   <= 1'b0;
      r_level   <= 2'd0;
      r_lives   <= LIVES_INIT;
    end else begin
      r_state   <= w_state_next;
      r_div     <= w_div_next;
      r_tc      <= w_tc_next;
      r_arm_cnt <= w_arm_next;
      r_rr      <= w_rr_next;
      r_step    <= w_step_next;
      r_spawn   <= w_spawn_next;
      r_stop    <= (w_state_next != S_PLAY);
      r_clear   <= w_clear_next;
      r_level   <= w_level_next;
      r_lives   <= w_lives_next;
    end
  end

  assign o_step  = r_step;
  assign o_spawn = r_spawn;
  assign o_stop  = r_stop;
  assign o_clear = r_clear;
  assign o_level = r_level;
  assign o_lives = r_lives;
  assign o_state = r_state;

endmodule
